// File: rtl/fpu_pkg.sv
// fpu_pkg: shared FPU constants, FP32 field layout and the divide/sqrt FSM and special-case encodings.
package fpu_pkg;
    localparam int OP_FDIV  = 3;
    localparam int OP_FSQRT = 4;
    localparam int EXP_W    = 8;
    localparam int MAN_W    = 23;
    localparam int BIAS     = 127;
    localparam logic [31:0] FP_QNAN = 32'h7FC00000;
    localparam logic [31:0] FP_PINF = 32'h7F800000;
    typedef enum logic [2:0] {ST_IDLE, ST_PREP, ST_ITER, ST_ROUND, ST_DONE} state_t;
    typedef enum logic [1:0] {SP_NONE, SP_NAN, SP_INF, SP_ZERO} special_t;
endpackage

// File: rtl/fpu_divsqrt_unit_if.sv
// fpu_divsqrt_unit_if: FPU opcode bus between the issue side (master) and the divide/sqrt unit (slave).
//   opcode/x1/x2 : one-hot operation pulse and binary32 operands from the issuer
//   y/ovf/unf    : result and flags, held until the next accepted operation
//   out_valid    : single-cycle completion pulse; busy: operation in flight
interface fpu_divsqrt_unit_if;
    logic [7:0]  opcode;
    logic [31:0] x1;
    logic [31:0] x2;
    logic [31:0] y;
    logic        ovf;
    logic        unf;
    logic        out_valid;
    logic        busy;
    modport master (output opcode, x1, x2, input y, ovf, unf, out_valid, busy);
    modport slave (input opcode, x1, x2, output y, ovf, unf, out_valid, busy);
endinterface

// File: rtl/fp32_round_pack.sv
// fp32_round_pack: round-to-nearest-even and pack a binary32 result, saturating to inf / flushing to zero.
//   sign, exp_in (biased, signed, may be out of range), mant (24-bit mantissa with hidden 1 + guard), sticky
//   y: packed result; ovf: exponent >= 255 after rounding; unf: exponent <= 0 after rounding
module fp32_round_pack
    import fpu_pkg::*;
(
    input  logic              sign,
    input  logic signed [9:0] exp_in,
    input  logic [24:0]       mant,
    input  logic              sticky,
    output logic [31:0]       y,
    output logic              ovf,
    output logic              unf
);
    logic              up;
    logic [24:0]       m;
    logic signed [9:0] e;

    always_comb begin
        up  = mant[0] & (sticky | mant[1]);
        m   = {1'b0, mant[24:1]} + {24'd0, up};
        // a carry out of the mantissa means it rounded up to 2.0
        e   = exp_in + $signed({9'd0, m[24]});
        ovf = e >= 10'sd255;
        unf = !ovf && e <= 10'sd0;
        y   = ovf ? {sign, FP_PINF[30:0]} :
              unf ? {sign, 31'd0} :
                    {sign, e[EXP_W-1:0], m[24] ? {MAN_W{1'b0}} : m[MAN_W-1:0]};
    end
endmodule

// File: rtl/fpu_divsqrt_unit.sv
// fpu_divsqrt_unit: iterative binary32 divide / square root responder on the FPU opcode bus.
//   clk, rstn : clock and synchronous active-low reset
//   bus       : slave side of fpu_divsqrt_unit_if (opcode bit 3 = fdiv, bit 4 = fsqrt)
module fpu_divsqrt_unit
    import fpu_pkg::*;
#(
    parameter int ITER = 26
) (
    input logic               clk,
    input logic               rstn,
    fpu_divsqrt_unit_if.slave bus
);
    // one extra leading step yields the always-zero weight-2 bit, so the
    // weight-1 bit of the quotient/root always lands in q[ITER-1]
    localparam int QW = ITER + 1;
    localparam int RW = ITER + 4;
    localparam int CW = $clog2(ITER + 1);

    state_t            state, state_nxt;
    special_t          sp, sp_nxt;
    logic [CW-1:0]     cnt;
    logic [31:0]       a, b, y, rp_y;
    logic              is_sqrt, sgn, sgn_nxt, ovf, unf, rp_ovf, rp_unf;
    logic              accept, ge, sticky;
    logic              a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
    logic signed [9:0] exp, exp_nxt, exp_adj, ue;
    logic [23:0]       ma, mb;
    logic [24:0]       m25, dvs;
    logic [RW-1:0]     rem, r2, trial, sub;
    logic [2*QW-1:0]   rad;
    logic [QW-1:0]     q;
    logic [ITER-1:0]   qn;

    assign accept        = (state == ST_IDLE || state == ST_DONE) && (bus.opcode[OP_FDIV] || bus.opcode[OP_FSQRT]);
    assign bus.y         = y;
    assign bus.ovf       = ovf;
    assign bus.unf       = unf;
    assign bus.out_valid = state == ST_DONE;
    assign bus.busy      = state != ST_IDLE;

    always_ff @(posedge clk)
        state <= rstn ? state_nxt : ST_IDLE;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  state_nxt = accept ? ST_PREP : ST_IDLE;
            ST_PREP:  state_nxt = ST_ITER;
            ST_ITER:  state_nxt = cnt == '0 ? ST_ROUND : ST_ITER;
            ST_ROUND: state_nxt = ST_DONE;
            ST_DONE:  state_nxt = accept ? ST_PREP : ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // unpack and classify; a zero exponent field (denormal) counts as zero
    always_comb begin
        a_zero  = a[30:23] == 8'd0;
        a_inf   = &a[30:23] && a[22:0] == 23'd0;
        a_nan   = &a[30:23] && a[22:0] != 23'd0;
        b_zero  = b[30:23] == 8'd0;
        b_inf   = &b[30:23] && b[22:0] == 23'd0;
        b_nan   = &b[30:23] && b[22:0] != 23'd0;
        ma      = {1'b1, a[22:0]};
        mb      = {1'b1, b[22:0]};
        ue      = $signed({2'b00, a[30:23]}) - 10'sd127;
        m25     = ue[0] ? {ma, 1'b0} : {1'b0, ma};
        sgn_nxt = is_sqrt ? a[31] : a[31] ^ b[31];
        exp_nxt = is_sqrt ? (ue >>> 1) + 10'sd127 :
                            $signed({2'b00, a[30:23]}) - $signed({2'b00, b[30:23]}) + 10'sd127;
        sp_nxt  = is_sqrt ?
                  ((a_nan || (a[31] && !a_zero)) ? SP_NAN : a_zero ? SP_ZERO : a_inf ? SP_INF : SP_NONE) :
                  ((a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) ? SP_NAN :
                   (a_inf || b_zero) ? SP_INF : (a_zero || b_inf) ? SP_ZERO : SP_NONE);
    end

    // one restoring step: divide compares against the divisor, sqrt against (root << 2) | 1
    always_comb begin
        r2    = is_sqrt ? {rem[RW-3:0], rad[2*QW-1 -: 2]} : rem;
        trial = is_sqrt ? RW'({q, 2'b01}) : RW'(dvs);
        ge    = r2 >= trial;
        sub   = ge ? r2 - trial : r2;
    end

    // normalize a sub-unity quotient; the sqrt root is always in [1, 2)
    always_comb begin
        qn      = q[ITER-1] ? q[ITER-1:0] : {q[ITER-2:0], 1'b0};
        exp_adj = q[ITER-1] ? exp : exp - 10'sd1;
        sticky  = (|qn[ITER-26:0]) || rem != '0;
    end

    fp32_round_pack u_round (
        .sign   (sgn),
        .exp_in (exp_adj),
        .mant   (qn[ITER-1 -: 25]),
        .sticky (sticky),
        .y      (rp_y),
        .ovf    (rp_ovf),
        .unf    (rp_unf)
    );

    always_ff @(posedge clk) begin
        if (accept) begin
            a       <= bus.x1;
            b       <= bus.x2;
            is_sqrt <= bus.opcode[OP_FSQRT];
        end
        if (state == ST_PREP) begin
            sp  <= sp_nxt;
            sgn <= sgn_nxt;
            exp <= exp_nxt;
            rem <= is_sqrt ? '0 : RW'(ma);
            dvs <= {mb, 1'b0};
            rad <= {2'b00, m25, {(2*QW-27){1'b0}}};
            q   <= '0;
        end
        if (state == ST_ITER) begin
            q   <= {q[QW-2:0], ge};
            rem <= is_sqrt ? sub : sub << 1;
            rad <= rad << 2;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt <= '0;
            y   <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            if (accept) begin
                ovf <= 1'b0;
                unf <= 1'b0;
            end
            if (state == ST_PREP)
                cnt <= CW'(ITER);
            if (state == ST_ITER)
                cnt <= cnt - 1'b1;
            if (state == ST_ROUND) begin
                y   <= sp == SP_NAN  ? FP_QNAN :
                       sp == SP_INF  ? {sgn, FP_PINF[30:0]} :
                       sp == SP_ZERO ? {sgn, 31'd0} : rp_y;
                ovf <= sp == SP_NONE && rp_ovf;
                unf <= sp == SP_NONE && rp_unf;
            end
        end
    end
endmodule
